// File: rtl/x1_pkg.sv
// Shared definitions for the X1 CRTC: register indices, blink modes,
// the decoded register bundle and default bus widths.
package x1_pkg;

  localparam int MA_W_DEF = 14;
  localparam int RA_W_DEF = 5;

  localparam logic [4:0] CRTC_R_HTOTAL = 5'd0;
  localparam logic [4:0] CRTC_R_HDISP  = 5'd1;
  localparam logic [4:0] CRTC_R_HSPOS  = 5'd2;
  localparam logic [4:0] CRTC_R_SYNCW  = 5'd3;
  localparam logic [4:0] CRTC_R_VTOTAL = 5'd4;
  localparam logic [4:0] CRTC_R_VADJ   = 5'd5;
  localparam logic [4:0] CRTC_R_VDISP  = 5'd6;
  localparam logic [4:0] CRTC_R_VSPOS  = 5'd7;
  localparam logic [4:0] CRTC_R_MODE   = 5'd8;
  localparam logic [4:0] CRTC_R_MAXRA  = 5'd9;
  localparam logic [4:0] CRTC_R_CURS   = 5'd10;
  localparam logic [4:0] CRTC_R_CURE   = 5'd11;
  localparam logic [4:0] CRTC_R_STAH   = 5'd12;
  localparam logic [4:0] CRTC_R_STAL   = 5'd13;
  localparam logic [4:0] CRTC_R_CURH   = 5'd14;
  localparam logic [4:0] CRTC_R_CURL   = 5'd15;
  localparam logic [4:0] CRTC_R_LPH    = 5'd16;
  localparam logic [4:0] CRTC_R_LPL    = 5'd17;

  typedef enum logic [1:0] {
    BLINK_ON  = 2'b00,
    BLINK_OFF = 2'b01,
    BLINK_16  = 2'b10,
    BLINK_32  = 2'b11
  } blink_t;

  typedef struct packed {
    logic [7:0]  htotal;
    logic [7:0]  hdisp;
    logic [7:0]  hsync_pos;
    logic [3:0]  vsw;
    logic [3:0]  hsw;
    logic [6:0]  vtotal;
    logic [4:0]  vadj;
    logic [6:0]  vdisp;
    logic [6:0]  vsync_pos;
    logic [4:0]  max_ra;
    blink_t      blink;
    logic [4:0]  cur_start;
    logic [4:0]  cur_end;
    logic [13:0] start_addr;
    logic [13:0] cur_addr;
  } crtc_regs_t;

endpackage

// File: rtl/x1_crtc_regs.sv
// CRTC register file: index latch, data writes and the R12-R17 read mux.
module x1_crtc_regs
  import x1_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cs,
  input  logic       rs,
  input  logic       wr,
  input  logic [7:0] din,
  output crtc_regs_t regs,
  output logic [7:0] dout
);

  logic [4:0] idx;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      idx  <= '0;
      regs <= '0;
    end else if (cs && wr) begin
      if (!rs) begin
        idx <= din[4:0];
      end else begin
        // R8 and indices above 15 are accepted and dropped
        case (idx)
          CRTC_R_HTOTAL: regs.htotal <= din;
          CRTC_R_HDISP:  regs.hdisp <= din;
          CRTC_R_HSPOS:  regs.hsync_pos <= din;
          CRTC_R_SYNCW: begin
            regs.hsw <= din[3:0];
            regs.vsw <= din[7:4];
          end
          CRTC_R_VTOTAL: regs.vtotal <= din[6:0];
          CRTC_R_VADJ:   regs.vadj <= din[4:0];
          CRTC_R_VDISP:  regs.vdisp <= din[6:0];
          CRTC_R_VSPOS:  regs.vsync_pos <= din[6:0];
          CRTC_R_MAXRA:  regs.max_ra <= din[4:0];
          CRTC_R_CURS: begin
            regs.cur_start <= din[4:0];
            regs.blink     <= blink_t'(din[6:5]);
          end
          CRTC_R_CURE:   regs.cur_end <= din[4:0];
          CRTC_R_STAH:   regs.start_addr[13:8] <= din[5:0];
          CRTC_R_STAL:   regs.start_addr[7:0] <= din;
          CRTC_R_CURH:   regs.cur_addr[13:8] <= din[5:0];
          CRTC_R_CURL:   regs.cur_addr[7:0] <= din;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dout = '0;
    case (idx)
      CRTC_R_STAH: dout = {2'b00, regs.start_addr[13:8]};
      CRTC_R_STAL: dout = regs.start_addr[7:0];
      CRTC_R_CURH: dout = {2'b00, regs.cur_addr[13:8]};
      CRTC_R_CURL: dout = regs.cur_addr[7:0];
      default:     dout = '0;
    endcase
  end

endmodule

// File: rtl/x1_crtc.sv
// HD46505-subset CRT controller for the Sharp X1 (timing, refresh address,
// sync/blank). Hardware cursor is built only with X1_CRTC_CURSOR_EN.
module x1_crtc
  import x1_pkg::*;
#(
  parameter int MA_W = MA_W_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_char,
  input  logic            cs,
  input  logic            rs,
  input  logic            wr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic [MA_W-1:0] ma,
  output logic [RA_W-1:0] ra,
  output logic            disp_en,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            cursor
);

  crtc_regs_t r;

  x1_crtc_regs u_regs (
    .clk_sys (clk_sys),
    .reset   (reset),
    .cs      (cs),
    .rs      (rs),
    .wr      (wr),
    .din     (din),
    .regs    (r),
    .dout    (dout)
  );

  logic [7:0]  hc, hc_n;
  logic [4:0]  rc, rc_n;
  logic [6:0]  vc, vc_n;
  logic        adj, adj_n;
  logic [4:0]  adj_cnt, adj_cnt_n;
  logic [13:0] base, base_n;
  logic [4:0]  frame, frame_n;
  logic        frame_end;
  logic        eol;
  logic        hs_n, vs_n;
  logic [3:0]  hs_cnt, hs_cnt_n;
  logic [3:0]  vs_cnt, vs_cnt_n;
  logic [13:0] addr_n;
  logic [MA_W-1:0] ma_n;
  logic        de_n;
  logic        cur_n;

  always_comb begin
    eol       = hc >= r.htotal;
    hc_n      = eol ? 8'd0 : hc + 8'd1;
    rc_n      = rc;
    vc_n      = vc;
    adj_n     = adj;
    adj_cnt_n = adj_cnt;
    base_n    = base;
    frame_end = 1'b0;
    if (eol) begin
      if (adj) begin
        if (adj_cnt + 5'd1 >= r.vadj) begin
          frame_end = 1'b1;
        end else begin
          adj_cnt_n = adj_cnt + 5'd1;
          rc_n      = rc + 5'd1;
        end
      end else if (rc >= r.max_ra) begin
        if (vc >= r.vtotal) begin
          if (r.vadj == 5'd0) begin
            frame_end = 1'b1;
          end else begin
            adj_n     = 1'b1;
            adj_cnt_n = 5'd0;
            rc_n      = rc + 5'd1;
          end
        end else begin
          rc_n   = 5'd0;
          vc_n   = vc + 7'd1;
          base_n = base + {6'd0, r.hdisp};
        end
      end else begin
        rc_n = rc + 5'd1;
      end
      if (frame_end) begin
        rc_n      = 5'd0;
        vc_n      = 7'd0;
        adj_n     = 1'b0;
        adj_cnt_n = 5'd0;
        base_n    = r.start_addr;
      end
    end
    frame_n = frame_end ? frame + 5'd1 : frame;
  end

  // sync pulses count down remaining characters / lines after the start
  always_comb begin
    hs_n     = hsync;
    hs_cnt_n = hs_cnt;
    if (hc_n == r.hsync_pos && r.hsw != 4'd0) begin
      hs_n     = 1'b1;
      hs_cnt_n = r.hsw - 4'd1;
    end else if (hsync) begin
      if (hs_cnt == 4'd0) hs_n = 1'b0;
      else hs_cnt_n = hs_cnt - 4'd1;
    end
  end

  always_comb begin
    vs_n     = vsync;
    vs_cnt_n = vs_cnt;
    if (eol) begin
      if (vc_n == r.vsync_pos && rc_n == 5'd0 && !adj_n) begin
        vs_n     = 1'b1;
        vs_cnt_n = r.vsw - 4'd1;
      end else if (vsync) begin
        if (vs_cnt == 4'd0) vs_n = 1'b0;
        else vs_cnt_n = vs_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    addr_n = base_n + {6'd0, hc_n};
    ma_n   = MA_W'(addr_n);
    de_n   = (hc_n < r.hdisp) && (vc_n < r.vdisp) && !adj_n;
  end

`ifdef X1_CRTC_CURSOR_EN
  logic blink32, blink32_n;
  logic gate;

  always_comb begin
    blink32_n = blink32 ^ (frame_end && frame == 5'd31);
    gate      = 1'b1;
    case (r.blink)
      BLINK_ON:  gate = 1'b1;
      BLINK_OFF: gate = 1'b0;
      BLINK_16:  gate = !frame_n[4];
      BLINK_32:  gate = !blink32_n;
      default:   gate = 1'b1;
    endcase
    cur_n = de_n && ma_n == MA_W'(r.cur_addr) &&
            rc_n >= r.cur_start && rc_n <= r.cur_end && gate;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) blink32 <= 1'b0;
    else if (ce_char) blink32 <= blink32_n;
  end
`else
  logic unused_cur;
  assign unused_cur = ^{r.blink, r.cur_start, r.cur_end,
                        r.cur_addr, frame};
  assign cur_n = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc      <= '0;
      rc      <= '0;
      vc      <= '0;
      adj     <= 1'b0;
      adj_cnt <= '0;
      base    <= '0;
      frame   <= '0;
      hs_cnt  <= '0;
      vs_cnt  <= '0;
      ma      <= '0;
      ra      <= '0;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
      hblank  <= 1'b1;
      vblank  <= 1'b1;
      disp_en <= 1'b0;
      cursor  <= 1'b0;
    end else if (ce_char) begin
      hc      <= hc_n;
      rc      <= rc_n;
      vc      <= vc_n;
      adj     <= adj_n;
      adj_cnt <= adj_cnt_n;
      base    <= base_n;
      frame   <= frame_n;
      hs_cnt  <= hs_cnt_n;
      vs_cnt  <= vs_cnt_n;
      ma      <= ma_n;
      ra      <= RA_W'(rc_n);
      hsync   <= hs_n;
      vsync   <= vs_n;
      hblank  <= !(hc_n < r.hdisp);
      vblank  <= !(vc_n < r.vdisp) || adj_n;
      disp_en <= de_n;
      cursor  <= cur_n;
    end
  end

endmodule

// File: tb/tb_x1_crtc.sv
// Directed bench for x1_crtc; cursor expectations follow X1_CRTC_CURSOR_EN.
module tb_x1_crtc;

`ifdef X1_CRTC_CURSOR_EN
  localparam logic CUR_ON = 1'b1;
`else
  localparam logic CUR_ON = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_char;
  logic        cs, rs, wr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        disp_en, hsync, vsync, hblank, vblank, cursor;

  int checks = 0;
  int failures = 0;
  int k = 0;

  x1_crtc dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_char (ce_char),
    .cs      (cs),
    .rs      (rs),
    .wr      (wr),
    .din     (din),
    .dout    (dout),
    .ma      (ma),
    .ra      (ra),
    .disp_en (disp_en),
    .hsync   (hsync),
    .vsync   (vsync),
    .hblank  (hblank),
    .vblank  (vblank),
    .cursor  (cursor)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wreg(input logic [7:0] idx, input logic [7:0] val);
    @(negedge clk_sys);
    cs = 1'b1; wr = 1'b1; rs = 1'b0; din = idx;
    @(negedge clk_sys);
    rs = 1'b1; din = val;
    @(negedge clk_sys);
    cs = 1'b0; wr = 1'b0; rs = 1'b0; din = 8'h00;
  endtask

  task automatic sel(input logic [7:0] idx);
    @(negedge clk_sys);
    cs = 1'b1; wr = 1'b1; rs = 1'b0; din = idx;
    @(negedge clk_sys);
    cs = 1'b0; wr = 1'b0; din = 8'h00;
  endtask

  task automatic hard_reset();
    @(negedge clk_sys);
    ce_char = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  task automatic start_ce();
    @(negedge clk_sys);
    ce_char = 1'b1;
    k = 0;
  endtask

  // advance to ce edge number t (strictly increasing) and sample mid-cycle
  task automatic adv(input int t);
    repeat (t - k) @(posedge clk_sys);
    k = t;
    @(negedge clk_sys);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce_char = 1'b1;
    cs = 1'b0; rs = 1'b0; wr = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_hblank", hblank, 1);
    check("rst_vblank", vblank, 1);
    check("rst_ma", ma, 0);
    check("rst_ra", ra, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_de", disp_en, 0);
    check("rst_cursor", cursor, 0);
    check("rst_dout", dout, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("zero_ma", ma, 0);
    check("zero_ra", ra, 0);
    check("zero_hblank", hblank, 1);

    // 56-char line, 26 rows of 8 rasters plus 2 adjust lines
    hard_reset();
    wreg(0, 55); wreg(1, 40); wreg(2, 45); wreg(3, 8'h24);
    wreg(4, 25); wreg(5, 2); wreg(6, 25); wreg(7, 20);
    wreg(9, 7); wreg(12, 8'h01); wreg(13, 8'h00);
    start_ce();
    adv(39);  check("hb_39", hblank, 0);
    adv(40);  check("hb_40", hblank, 1);
    adv(44);  check("hs_44", hsync, 0);
    adv(45);  check("hs_45", hsync, 1);
    adv(48);  check("hs_48", hsync, 1);
    adv(49);  check("hs_49", hsync, 0);
    adv(55);  check("ra_55", ra, 0); check("hb_55", hblank, 1);
    adv(56);  check("ra_56", ra, 1); check("hb_56", hblank, 0);
    adv(61);  check("ma_61", ma, 5);
    adv(448); check("ma_row1", ma, 14'h28); check("ra_row1", ra, 0);
    adv(159*56+55); check("vs_pre", vsync, 0);
    adv(160*56);    check("vs_on", vsync, 1);
    adv(161*56+55); check("vs_l2", vsync, 1);
    adv(162*56);    check("vs_off", vsync, 0);
    adv(199*56);    check("vb_199", vblank, 0); check("de_199", disp_en, 1);
    adv(200*56);    check("vb_200", vblank, 1); check("de_200", disp_en, 0);
    adv(210*56-1);  check("vb_adj", vblank, 1);
    adv(210*56);
    check("f1_ma", ma, 14'h0100);
    check("f1_ra", ra, 0);
    check("f1_vb", vblank, 0);
    adv(218*56);    check("f1_row1", ma, 14'h0128);

    // single-line frame starting at 0x3FF0
    hard_reset();
    wreg(0, 55); wreg(1, 40); wreg(4, 0); wreg(5, 0);
    wreg(6, 1); wreg(9, 0); wreg(12, 8'h3F); wreg(13, 8'hF0);
    start_ce();
    adv(56); check("wr_start", ma, 14'h3FF0);
    adv(71); check("wr_top", ma, 14'h3FFF);
    adv(72); check("wr_zero", ma, 14'h0000);
    check("wr_known", {31'd0, $isunknown(ma)}, 0);

    // one 8-raster row per frame, cursor at 0x0105 rasters 6-7
    hard_reset();
    wreg(0, 55); wreg(1, 40); wreg(4, 0); wreg(5, 0);
    wreg(6, 1); wreg(9, 7); wreg(10, 8'h46); wreg(11, 7);
    wreg(12, 8'h01); wreg(13, 8'h00); wreg(14, 8'h01); wreg(15, 8'h05);
    start_ce();
    adv(448+5*56+5);    check("cur_ra5", cursor, 0);
    adv(448+6*56+5);    check("cur_ra6", cursor, CUR_ON);
    adv(448+6*56+6);    check("cur_hc6", cursor, 0);
    adv(448+7*56+5);    check("cur_ra7", cursor, CUR_ON);
    adv(448*16+6*56+5); check("cur_f16", cursor, 0);
    adv(448*32+6*56+5); check("cur_f32", cursor, CUR_ON);

    // shrink R0 under a live hc of 30
    adv(448*32+6*56+30);
    ce_char = 1'b0;
    check("hc30_ma", ma, 14'h011E);
    wreg(0, 10);
    ce_char = 1'b1;
    @(negedge clk_sys);
    ce_char = 1'b0;
    check("r0_wrap", ma, 14'h0100);

    wreg(20, 8'hFF);
    check("idx20_dout", dout, 0);
    sel(14); check("rd_r14", dout, 8'h01);
    sel(15); check("rd_r15", dout, 8'h05);
    sel(12); check("rd_r12", dout, 8'h01);
    sel(16); check("rd_r16", dout, 0);
    sel(0);  check("rd_r0", dout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
